decode_pipe: RTL and testbench
==============================

Name: decode_pipe

Overview:
- Registered, parametrised RV32I decode stage that sits between fetch and execute.
- Accepts raw instruction words with PC over a valid/ready handshake, decodes fields and immediate, and flags illegal encodings.
- Results are buffered in a small FIFO so fetch can run ahead while execute stalls.
- Supports XLEN 32 or 64 immediate extension, plus flush for branch and jump redirects.

Parameters:
- XLEN, 32, datapath width; immediates and PC are XLEN bits; legal values are 32 and 64.
- BUF_DEPTH, 2, number of decoded-entry slots; a power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries and of the same-cycle input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode can accept; equals !full.
- in_ins  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_ins.
- out_valid  out  1  head entry is valid; equals !empty.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_imm  out  XLEN  sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  5 each  register indices, ins[19:15], ins[24:20], ins[11:7].
- out_op  out  7  ins[6:0].
- out_func  out  3  ins[14:12].
- out_func1  out  1  ins[30] (sub / arithmetic right shift).
- out_illegal  out  1  head entry is an illegal encoding.

Behaviour:
- Handshake:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - in_ready = (count != BUF_DEPTH), taken from registered count only; no combinational path from out_ready.
- Latency: an entry accepted at edge N has out_valid=1 after edge N; one cycle minimum.
- Full buffer: in_ready=0 even if a pop occurs in the same cycle; the freed slot is visible in the next cycle.
- Simultaneous push and pop when 0 < count < BUF_DEPTH: count is unchanged and both pointers advance.
- Empty buffer: out_valid=0 and all out_* fields are driven to 0.
- Ordering: entries leave in strict FIFO order. Pointers wrap modulo BUF_DEPTH. count has width clog2(BUF_DEPTH)+1.
- Flush: at the next edge count, wr_ptr and rd_ptr become 0. The input presented in the flush cycle is dropped, and no pop is counted.
- Reset, asserted at any time including mid-transfer: count=0, pointers=0, out_valid=0, in_ready=1, all outputs 0. Storage arrays need no reset.
- Decode is computed combinationally from in_ins and written into the slot at wr_ptr on push.
- Immediate format by opcode:
  - I-format: jalr 1100111, load 0000011, I_type 0010011.
  - U-format: lui 0110111, auipc 0010111.
  - J-format: jal 1101111.
  - B-format: B_type 1100011.
  - S-format: store 0100011.
  - All other opcodes: imm = 0.
- Immediate extension:
  - Every format is sign-extended from ins[31] to XLEN, including U-format when XLEN=64.
  - B and J immediates have bit 0 = 0.
  - U-format lower 12 bits are 0.
- out_illegal = 1 if any of:
  - ins[1:0] != 2'b11;
  - opcode is not one of the 9 above, fence 0001111, or system 1110011;
  - R_type 0110011 with ins[31:25] other than 0000000 or 0100000;
  - R_type with ins[31:25]=0100000 and func not 000 or 101;
  - I_type with func=001 and ins[31:25]!=0;
  - I_type with func=101 and ins[31:25] not 0000000 or 0100000.
- Illegal entries are buffered and delivered like any other entry; imm=0 for them.

Decomposition:
- Shared define include: existing opcode macros (lui, auipc, jal, jalr, B_type, load, store, I_type, R_type, zero_word) plus new fence and system macros.
- Sub-module imm_gen (parameter XLEN): purely combinational; in: ins[31:0]; out: imm[XLEN-1:0], is_illegal.
- decode_pipe holds the FIFO, handshake and flush logic.

Test Plan:
- Reset then single push of 0xFFF00093 (addi x1,x0,-1), pc=0x100, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, rd=1, rs1=0, op=0x13, pc=0x100; following cycle out_valid=0.
- XLEN=64, push 0x800000B7 (lui) -> imm=0xFFFFFFFF80000000. Push 0xFE000EE3 (beq back) -> imm sign-extended, bit0=0.
- BUF_DEPTH=2, out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 on the third. Raise out_ready -> entries out in order. in_ready returns the cycle after the first pop.
- Fill 1 entry, then assert flush together with in_valid -> next cycle out_valid=0, count=0; flushed input is never emitted.
- Push 0x00000000, 0x4000_1033 (illegal R func), 0x0000100F (fence) -> out_illegal=1, 1, 0; imm=0 for the illegal entries.
- Assert rst mid-stream with 2 entries buffered -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_pipe_pkg.sv
// rtl/decode_pipe_pkg.sv - RV32I opcode constants and immediate-format helper shared by the decode stage
// Contents: major opcode values (ins[6:0]), funct7 values checked by the
// illegal-encoding filter, and a helper mapping an opcode to its immediate format.
package decode_pipe_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_JALR, OP_LOAD, OP_IMM: imm_fmt = FMT_I;
      OP_LUI, OP_AUIPC:         imm_fmt = FMT_U;
      OP_JAL:                   imm_fmt = FMT_J;
      OP_BRANCH:                imm_fmt = FMT_B;
      OP_STORE:                 imm_fmt = FMT_S;
      default:                  imm_fmt = FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_pipe_imm_gen.sv
// rtl/decode_pipe_imm_gen.sv - combinational immediate extraction and illegal-encoding detection
// Ports:
//   ins        in  32    raw instruction word
//   imm        out XLEN  sign-extended immediate (0 for formatless or illegal words)
//   is_illegal out 1     encoding is not a supported RV32I instruction
module imm_gen
  import decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  output logic [XLEN-1:0] imm,
  output logic            is_illegal
);

  logic [6:0]  op;
  logic [2:0]  func;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic        known_op;
  logic        f7_ok;

  assign op    = ins[6:0];
  assign func  = ins[14:12];
  assign f7    = ins[31:25];
  assign f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);

  always_comb begin
    imm32 = ZERO_WORD;
    case (imm_fmt(op))
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = ZERO_WORD;
    endcase
  end

  always_comb begin
    known_op = (imm_fmt(op) != FMT_NONE) || (op == OP_REG) ||
               (op == OP_FENCE) || (op == OP_SYSTEM);
    is_illegal = (ins[1:0] != 2'b11) || !known_op;
    if (op == OP_REG) begin
      if (!f7_ok) is_illegal = 1'b1;
      // Only sub and sra use the alternate funct7.
      if (f7 == F7_ALT && func != 3'b000 && func != 3'b101) is_illegal = 1'b1;
    end
    if (op == OP_IMM) begin
      if (func == 3'b001 && f7 != F7_BASE) is_illegal = 1'b1;
      if (func == 3'b101 && !f7_ok)        is_illegal = 1'b1;
    end
  end

  // Signed size cast sign-extends from bit 31 for XLEN=64, including U-format.
  assign imm = is_illegal ? '0 : XLEN'($signed(imm32));

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - registered RV32I decode stage with a BUF_DEPTH-entry output FIFO
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   flush                         drop all buffered entries and the same-cycle input
//   in_valid/in_ready/in_ins/in_pc   fetch side handshake, instruction and PC
//   out_valid/out_ready           execute side handshake
//   out_pc, out_imm               head entry PC and sign-extended immediate
//   out_rs1/out_rs2/out_rd        register indices
//   out_op/out_func/out_func1     opcode, funct3, ins[30]
//   out_illegal                   head entry is an illegal encoding
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_op,
  output logic [2:0]      out_func,
  output logic            out_func1,
  output logic            out_illegal
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  // Raw word is kept per slot; the register/opcode fields are plain slices of it.
  logic [31:0]     ins_mem [BUF_DEPTH];
  logic [XLEN-1:0] pc_mem  [BUF_DEPTH];
  logic [XLEN-1:0] imm_mem [BUF_DEPTH];
  logic            ill_mem [BUF_DEPTH];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ins        (in_ins),
    .imm        (dec_imm),
    .is_illegal (dec_illegal)
  );

  // Ready comes from registered count only, so a full buffer stays not-ready
  // even in a cycle that pops.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[wr_ptr] <= in_ins;
      pc_mem[wr_ptr]  <= in_pc;
      imm_mem[wr_ptr] <= dec_imm;
      ill_mem[wr_ptr] <= dec_illegal;
    end
  end

  always_comb begin
    out_pc      = '0;
    out_imm     = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_rd      = '0;
    out_op      = '0;
    out_func    = '0;
    out_func1   = 1'b0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = pc_mem[rd_ptr];
      out_imm     = imm_mem[rd_ptr];
      out_rs1     = ins_mem[rd_ptr][19:15];
      out_rs2     = ins_mem[rd_ptr][24:20];
      out_rd      = ins_mem[rd_ptr][11:7];
      out_op      = ins_mem[rd_ptr][6:0];
      out_func    = ins_mem[rd_ptr][14:12];
      out_func1   = ins_mem[rd_ptr][30];
      out_illegal = ill_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - directed self-checking bench for decode_pipe at XLEN 32 and 64
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ins = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        r32, v32, f1_32, il32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rs1_32, rs2_32, rd32;
  logic [6:0]  op32;
  logic [2:0]  fn32;

  logic        r64, v64, f1_64, il64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rs1_64, rs2_64, rd64;
  logic [6:0]  op64;
  logic [2:0]  fn64;

  int checks = 0;
  int passed = 0;

  decode_pipe #(.XLEN(32), .BUF_DEPTH(2)) d32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_ins(in_ins), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_pc(pc32), .out_imm(imm32), .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32),
    .out_op(op32), .out_func(fn32), .out_func1(f1_32), .out_illegal(il32)
  );

  decode_pipe #(.XLEN(64), .BUF_DEPTH(2)) d64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_pc(pc64), .out_imm(imm64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64),
    .out_op(op64), .out_func(fn64), .out_func1(f1_64), .out_illegal(il64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vectors streamed at one per cycle with out_ready high.
  logic [31:0] vec_ins [6];
  logic [31:0] vec_imm [6];
  logic        vec_ill [6];

  initial begin
    vec_ins[0] = 32'h0020A423; vec_imm[0] = 32'h00000008; vec_ill[0] = 1'b0; // sw x2,8(x1)
    vec_ins[1] = 32'hFFDFF0EF; vec_imm[1] = 32'hFFFFFFFC; vec_ill[1] = 1'b0; // jal x1,-4
    vec_ins[2] = 32'h00000000; vec_imm[2] = 32'h00000000; vec_ill[2] = 1'b1; // zero word
    vec_ins[3] = 32'h40001033; vec_imm[3] = 32'h00000000; vec_ill[3] = 1'b1; // R alt f7, func 001
    vec_ins[4] = 32'h7FF01093; vec_imm[4] = 32'h00000000; vec_ill[4] = 1'b1; // slli bad f7
    vec_ins[5] = 32'h0000100F; vec_imm[5] = 32'h00000000; vec_ill[5] = 1'b0; // fence

    // Reset
    #2 rst = 1'b1;
    tick();
    chk("rst_valid32", 64'(v32), 64'd0);
    chk("rst_ready64", 64'(r64), 64'd1);
    chk("rst_imm32", 64'(imm32), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_valid64", 64'(v64), 64'd0);

    // addi x1,x0,-1
    out_ready = 1'b1; in_valid = 1'b1; in_ins = 32'hFFF00093; in_pc = 64'h100;
    tick();
    in_valid = 1'b0;
    chk("addi_valid", 64'(v32), 64'd1);
    chk("addi_imm32", 64'(imm32), 64'hFFFFFFFF);
    chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_rd", 64'(rd32), 64'd1);
    chk("addi_rs1", 64'(rs1_32), 64'd0);
    chk("addi_op", 64'(op32), 64'h13);
    chk("addi_pc", 64'(pc32), 64'h100);
    chk("addi_ill", 64'(il32), 64'd0);
    tick();
    chk("addi_drained", 64'(v32), 64'd0);
    chk("empty_imm64", imm64, 64'd0);

    // lui then beq, back to back, popped as they arrive
    in_valid = 1'b1; in_ins = 32'h800000B7; in_pc = 64'h104;
    tick();
    in_ins = 32'hFE000EE3; in_pc = 64'h108;
    chk("lui_imm32", 64'(imm32), 64'h80000000);
    chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui_op", 64'(op64), 64'h37);
    tick();
    in_valid = 1'b0;
    chk("beq_valid", 64'(v64), 64'd1);
    chk("beq_imm32", 64'(imm32), 64'hFFFFFFFC);
    chk("beq_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_pc64", pc64, 64'h108);
    tick();
    chk("beq_drained", 64'(v64), 64'd0);

    // Back-pressure: three offers, only two fit
    out_ready = 1'b0; in_valid = 1'b1; in_ins = 32'h00500113; in_pc = 64'h200;
    tick();
    in_ins = 32'h00A00193; in_pc = 64'h204;
    chk("bp_ready_1", 64'(r32), 64'd1);
    tick();
    in_ins = 32'h00F00213; in_pc = 64'h208;
    chk("bp_full_ready", 64'(r32), 64'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_ready_while_pop", 64'(r64), 64'd0);
    chk("bp_head_pc", 64'(pc32), 64'h200);
    chk("bp_head_imm", 64'(imm32), 64'd5);
    tick();
    chk("bp_ready_after_pop", 64'(r32), 64'd1);
    chk("bp_second_pc", 64'(pc32), 64'h204);
    chk("bp_second_rd", 64'(rd32), 64'd3);
    tick();
    chk("bp_third_dropped", 64'(v32), 64'd0);

    // Flush together with a new input
    out_ready = 1'b0; in_valid = 1'b1; in_ins = 32'h00100293; in_pc = 64'h300;
    tick();
    chk("fl_filled", 64'(v32), 64'd1);
    in_ins = 32'h00200313; in_pc = 64'h304; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(v32), 64'd0);
    chk("fl_ready", 64'(r64), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_input_dropped", 64'(v64), 64'd0);

    // Streamed vectors: legal, illegal and fence, one push and one pop per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_ins = vec_ins[i]; in_pc = 64'h400 + 64'(i * 4);
      tick();
      chk($sformatf("vec%0d_pc", i), 64'(pc32), 64'h400 + 64'(i * 4));
      chk($sformatf("vec%0d_imm", i), 64'(imm32), 64'(vec_imm[i]));
      chk($sformatf("vec%0d_ill", i), 64'(il64), 64'(vec_ill[i]));
    end
    in_valid = 1'b0;
    tick();
    chk("vec_drained", 64'(v32), 64'd0);

    // Decoded fields of the illegal R-type word
    in_valid = 1'b1; in_ins = 32'h40001033; in_pc = 64'h480;
    tick();
    in_valid = 1'b0;
    chk("r_op", 64'(op32), 64'h33);
    chk("r_func", 64'(fn32), 64'd1);
    chk("r_func1", 64'(f1_32), 64'd1);
    tick();

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0; in_valid = 1'b1; in_ins = 32'h00100093; in_pc = 64'h500;
    tick();
    in_ins = 32'h00200093; in_pc = 64'h504;
    tick();
    in_valid = 1'b0;
    chk("ar_full", 64'(r32), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid32", 64'(v32), 64'd0);
    chk("ar_ready32", 64'(r32), 64'd1);
    chk("ar_valid64", 64'(v64), 64'd0);
    chk("ar_pc64", pc64, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_stays_empty", 64'(v32), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
